// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives a combinational instruction memory and
// holds one fetched word in an instruction register for execute (valid/ready).
// Ports: clock, reset_n (sync, active-low); run/halt control; imem_address/
// imem_data memory side; ir/ir_pc/ir_valid/ir_ready execute side;
// jump_valid/jump_address redirect; pc, fetch_count, state status.
module instruction_fetch #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               run,
  input  logic               halt,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_address,
  output logic [ADDR_W-1:0]  pc,
  output logic [15:0]        fetch_count,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic [ADDR_W-1:0]  ir_pc_q;
  logic               ir_valid_q;
  logic [15:0]        count_q;

  logic consume;
  logic leave_run;
  logic load;
  logic take_jump;
  logic restart;

  assign consume = ir_valid_q & ir_ready;

  always_comb begin
    state_d   = state_q;
    leave_run = 1'b0;
    load      = 1'b0;
    take_jump = 1'b0;
    restart   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d = RUN;
          restart = 1'b1;
        end
      end
      RUN: begin
        leave_run = halt | ~run;
        take_jump = jump_valid;
        load      = ~jump_valid & (~ir_valid_q | ir_ready)
                    & ~halt & run;
        if (leave_run) state_d = HALTED;
      end
      HALTED: begin
        take_jump = jump_valid;
        if (!run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      if (consume && count_q != 16'hFFFF)
        count_q <= count_q + 16'd1;
      // Jump beats load; a jump also drops the held word.
      if (restart) begin
        pc_q <= RESET_PC;
      end else if (take_jump) begin
        pc_q <= jump_address;
      end else if (load) begin
        pc_q <= pc_q + ADDR_W'(1);
      end
      if (load) begin
        ir_q    <= imem_data;
        ir_pc_q <= pc_q;
      end
      if (take_jump || leave_run) begin
        ir_valid_q <= 1'b0;
      end else if (load) begin
        ir_valid_q <= 1'b1;
      end else if (consume) begin
        ir_valid_q <= 1'b0;
      end
    end
  end

  assign imem_address = pc_q;
  assign pc           = pc_q;
  assign ir           = ir_q;
  assign ir_pc        = ir_pc_q;
  assign ir_valid     = ir_valid_q;
  assign fetch_count  = count_q;
  assign state        = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: spec-level model checked every cycle
// plus directed scenarios with hand-computed literal expectations.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        run;
  logic        halt;
  logic [7:0]  imem_address;
  logic [31:0] imem_data;
  logic [31:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        jump_valid;
  logic [7:0]  jump_address;
  logic [7:0]  pc;
  logic [15:0] fetch_count;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];

  always #5 clock = ~clock;

  assign imem_data = mem[imem_address];

  instruction_fetch dut (
    .clock(clock),
    .reset_n(reset_n),
    .run(run),
    .halt(halt),
    .imem_address(imem_address),
    .imem_data(imem_data),
    .ir(ir),
    .ir_pc(ir_pc),
    .ir_valid(ir_valid),
    .ir_ready(ir_ready),
    .jump_valid(jump_valid),
    .jump_address(jump_address),
    .pc(pc),
    .fetch_count(fetch_count),
    .state(state)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state as 0 idle / 1 run / 2 halted, one held slot.
  bit          live = 0;
  int          m_st;
  int          m_pc;
  logic [31:0] m_ir;
  int          m_irpc;
  bit          m_val;
  int          m_cnt;

  always @(posedge clock) begin
    bit hs;
    bit stop;
    if (!reset_n) begin
      live   = 1;
      m_st   = 0;
      m_pc   = 0;
      m_ir   = 0;
      m_irpc = 0;
      m_val  = 0;
      m_cnt  = 0;
    end else if (live) begin
      hs = m_val && ir_ready;
      if (hs) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      if (m_st == 0) begin
        if (run) begin
          m_st = 1;
          m_pc = 0;
        end
      end else if (m_st == 1) begin
        stop = halt || !run;
        if (jump_valid) begin
          m_pc  = jump_address;
          m_val = 0;
        end else if (!stop && (!m_val || ir_ready)) begin
          m_ir   = mem[m_pc];
          m_irpc = m_pc;
          m_val  = 1;
          m_pc   = (m_pc + 1) % 256;
        end else if (hs) begin
          m_val = 0;
        end
        if (stop) begin
          m_val = 0;
          m_st  = 2;
        end
      end else begin
        if (jump_valid) m_pc = jump_address;
        if (!run) m_st = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (live) begin
      check("m_state", 32'(state), 32'(m_st));
      check("m_pc", 32'(pc), 32'(m_pc));
      check("m_addr", 32'(imem_address), 32'(m_pc));
      check("m_valid", 32'(ir_valid), 32'(m_val));
      check("m_count", 32'(fetch_count), 32'(m_cnt));
      if (m_val) begin
        check("m_ir", ir, m_ir);
        check("m_irpc", 32'(ir_pc), 32'(m_irpc));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int c0;
    int p0;
    int guard;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);
    mem[100] = 32'h0;
    reset_n = 0;
    run = 1;
    halt = 0;
    ir_ready = 1;
    jump_valid = 0;
    jump_address = 0;

    // 1: streaming fetch after reset
    tick();
    tick();
    check("rst_state", 32'(state), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_valid", 32'(ir_valid), 0);
    reset_n = 1;
    tick();
    check("t1_run", 32'(state), 1);
    check("t1_novalid", 32'(ir_valid), 0);
    tick();
    check("t1_irpc0", 32'(ir_pc), 0);
    check("t1_ir0", ir, 1);
    check("t1_cnt0", 32'(fetch_count), 0);
    tick();
    check("t1_irpc1", 32'(ir_pc), 1);
    check("t1_cnt1", 32'(fetch_count), 1);
    tick();
    check("t1_irpc2", 32'(ir_pc), 2);
    tick();
    check("t1_irpc3", 32'(ir_pc), 3);
    check("t1_cnt3", 32'(fetch_count), 3);
    tick();
    tick();

    // 2: backpressure
    check("t2_irpc5", 32'(ir_pc), 5);
    ir_ready = 0;
    repeat (4) tick();
    check("t2_hold_irpc", 32'(ir_pc), 5);
    check("t2_hold_ir", ir, 6);
    check("t2_hold_pc", 32'(pc), 6);
    check("t2_hold_cnt", 32'(fetch_count), 5);
    ir_ready = 1;
    tick();
    check("t2_irpc6", 32'(ir_pc), 6);
    check("t2_cnt6", 32'(fetch_count), 6);

    // 3: jump with backpressure flushes the held word
    guard = 0;
    while (ir_pc != 8'd13 && guard < 40) begin
      tick();
      guard++;
    end
    check("t3_reach13", 32'(ir_pc), 13);
    ir_ready = 0;
    jump_valid = 1;
    jump_address = 0;
    tick();
    check("t3_flush", 32'(ir_valid), 0);
    check("t3_pc0", 32'(pc), 0);
    jump_valid = 0;
    tick();
    check("t3_irpc0", 32'(ir_pc), 0);
    check("t3_ir", ir, 1);
    check("t3_pc1", 32'(pc), 1);

    // 4: jump near top and wrap
    ir_ready = 1;
    jump_valid = 1;
    jump_address = 8'd254;
    tick();
    check("t4_pc254", 32'(pc), 254);
    check("t4_bubble", 32'(ir_valid), 0);
    jump_valid = 0;
    tick();
    check("t4_irpc254", 32'(ir_pc), 254);
    check("t4_ir254", ir, 255);
    tick();
    check("t4_irpc255", 32'(ir_pc), 255);
    check("t4_pcwrap", 32'(pc), 0);
    tick();
    check("t4_irpc0", 32'(ir_pc), 0);
    tick();
    check("t4_irpc1", 32'(ir_pc), 1);

    // 5: halt, jump in halted/idle, restart
    c0 = fetch_count;
    p0 = pc;
    halt = 1;
    tick();
    check("t5_cnt", 32'(fetch_count), 32'(c0 + 1));
    check("t5_halted", 32'(state), 2);
    check("t5_novalid", 32'(ir_valid), 0);
    check("t5_pc", 32'(pc), 32'(p0));
    halt = 0;
    tick();
    check("t5_stay", 32'(state), 2);
    check("t5_frozen", 32'(pc), 32'(p0));
    jump_valid = 1;
    jump_address = 8'h40;
    tick();
    check("t5_hjump", 32'(pc), 32'h40);
    check("t5_hnofetch", 32'(ir_valid), 0);
    jump_valid = 0;
    run = 0;
    tick();
    check("t5_idle", 32'(state), 0);
    jump_valid = 1;
    jump_address = 8'h80;
    tick();
    check("t5_ijump", 32'(pc), 32'h40);
    jump_valid = 0;
    run = 1;
    tick();
    check("t5_restart", 32'(state), 1);
    check("t5_rpc", 32'(pc), 0);
    tick();
    check("t5_irpc0", 32'(ir_pc), 0);
    check("t5_valid", 32'(ir_valid), 1);

    // 6: reset mid-run beats a jump, then saturating count
    jump_valid = 1;
    jump_address = 8'h10;
    reset_n = 0;
    tick();
    check("t6_state", 32'(state), 0);
    check("t6_pc", 32'(pc), 0);
    check("t6_ir", ir, 0);
    check("t6_irpc", 32'(ir_pc), 0);
    check("t6_valid", 32'(ir_valid), 0);
    check("t6_cnt", 32'(fetch_count), 0);
    reset_n = 1;
    jump_valid = 0;
    guard = 0;
    while (m_cnt < 65534 && guard < 70000) begin
      tick();
      guard++;
    end
    check("t6_fffe", 32'(fetch_count), 32'hFFFE);
    tick();
    check("t6_ffff", 32'(fetch_count), 32'hFFFF);
    tick();
    check("t6_sat", 32'(fetch_count), 32'hFFFF);
    tick();
    check("t6_sat2", 32'(fetch_count), 32'hFFFF);
    check("t6_valid", 32'(ir_valid), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
